// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter FSM encoding,
// default requester count / data width and the gap counter width.
package uart_pkg;

  localparam int unsigned UART_ARB_N  = 4;
  localparam int unsigned UART_DATA_W = 9;
  localparam int unsigned GAP_CNT_W   = 16;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_e;

endpackage : uart_pkg

// File: rtl/rr_picker.sv
// Round-robin priority picker: returns the first set bit of valid_i,
// searching upward from ptr_i+1 and wrapping modulo N.
module rr_picker #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         valid_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         onehot_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 found_o
);

  localparam int unsigned IW = $clog2(N);
  // One extra bit so ptr+k (at most 2N-1) never overflows before the wrap.
  localparam logic [IW:0] N_L = (IW+1)'(N);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // NOTE: every variable assigned in a combinational block gets a default
  // first; otherwise any path that skips an assignment infers a latch.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found_o  = 1'b0;
    sum      = '0;
    cand     = '0;
    for (int k = 1; k <= int'(N); k++) begin
      sum = {1'b0, ptr_i} + (IW+1)'(k);
      if (sum >= N_L) sum = sum - N_L;
      cand = sum[IW-1:0];
      if (!found_o && valid_i[cand]) begin
        found_o        = 1'b1;
        idx_o          = cand;
        onehot_o[cand] = 1'b1;
      end
    end
  end

endmodule : rr_picker

// File: rtl/uart_tx_arbiter.sv
// Frame-level round-robin arbiter in front of a UART transmitter, with a
// programmable idle gap enforced after each frame.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N = UART_ARB_N,
  parameter int unsigned W = UART_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           io_in_valid,
  input  logic [N*W-1:0]         io_in_bits,
  input  logic [N-1:0]           io_in_last,
  output logic [N-1:0]           io_in_ready,
  output logic                   io_out_valid,
  output logic [W-1:0]           io_out_bits,
  input  logic                   io_out_ready,
  input  logic [GAP_CNT_W-1:0]   io_gapCycles,
  output logic [$clog2(N)-1:0]   io_grant,
  output logic                   io_busy
);

  localparam int unsigned IW = $clog2(N);
  localparam logic [GAP_CNT_W-1:0] CNT_ONE = GAP_CNT_W'(1);

  arb_state_e           state_q, state_d;
  logic [GAP_CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [N-1:0]         owner_oh_q, owner_oh_d;

  logic [N-1:0]  pick_oh;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic [W-1:0]  words [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign words[i] = io_in_bits[i*W +: W];
  end

  rr_picker #(.N(N)) u_picker (
    .valid_i  (io_in_valid),
    .ptr_i    (ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .found_o  (pick_found)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    owner_oh_d   = owner_oh_q;
    io_out_valid = 1'b0;
    io_in_ready  = '0;
    io_out_bits  = words[grant_q];

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          ptr_d      = pick_idx;
          owner_oh_d = pick_oh;
          state_d    = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        io_out_valid = io_in_valid[grant_q];
        io_in_ready  = owner_oh_q & {N{io_out_ready}};
        // Only the owner's final handshake releases the grant.
        if (io_out_valid && io_out_ready && io_in_last[grant_q]) begin
          if (io_gapCycles == '0) begin
            state_d = ARB_IDLE;
          end else begin
            cnt_d   = io_gapCycles;
            state_d = ARB_GAP;
          end
        end
      end
      ARB_GAP: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    // Reset silences the handshake in the very cycle it is asserted.
    if (reset) begin
      io_out_valid = 1'b0;
      io_in_ready  = '0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      cnt_q      <= '0;
      ptr_q      <= IW'(N-1);
      grant_q    <= '0;
      owner_oh_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      owner_oh_q <= owner_oh_d;
    end
  end

  assign io_grant = grant_q;
  assign io_busy  = !reset && (state_q != ARB_IDLE);

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues feed the DUT,
// expected (grant, word) pairs are queued and checked on every output handshake.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 9;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   io_in_valid;
  logic [N*W-1:0] io_in_bits;
  logic [N-1:0]   io_in_last;
  logic [N-1:0]   io_in_ready;
  logic           io_out_valid;
  logic [W-1:0]   io_out_bits;
  logic           io_out_ready;
  logic [15:0]    io_gapCycles;
  logic [1:0]     io_grant;
  logic           io_busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_bits   (io_in_bits),
    .io_in_last   (io_in_last),
    .io_in_ready  (io_in_ready),
    .io_out_valid (io_out_valid),
    .io_out_bits  (io_out_bits),
    .io_out_ready (io_out_ready),
    .io_gapCycles (io_gapCycles),
    .io_grant     (io_grant),
    .io_busy      (io_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Requester sources: per-requester word/last arrays consumed on handshake.
  logic [W-1:0] src_data [N][16];
  logic         src_last [N][16];
  int           head [N];
  int           tail [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      io_in_valid[i]       = head[i] < tail[i];
      io_in_bits[i*W +: W] = src_data[i][head[i] % 16];
      io_in_last[i]        = src_last[i][head[i] % 16];
    end
  end

  logic [N-1:0] hs;
  always @(posedge clk) begin
    hs = io_in_valid & io_in_ready;
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) head[i] = head[i] + 1;
  end

  task automatic push_word(input int r, input logic [W-1:0] d, input logic l);
    src_data[r][tail[r]] = d;
    src_last[r][tail[r]] = l;
    tail[r] = tail[r] + 1;
  endtask

  // Scoreboard
  typedef struct packed {
    logic [1:0]   g;
    logic [W-1:0] d;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic expect_word(input int g, input logic [W-1:0] d);
    exp_t e;
    e.g = 2'(g);
    e.d = d;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (io_out_valid && io_out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_word", {21'd0, io_grant, io_out_bits}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_grant", 32'(io_grant), 32'(mon_e.g));
        check("sb_bits", 32'(io_out_bits), 32'(mon_e.d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      tick();
      done = !io_busy;
      for (int i = 0; i < N; i++) if (head[i] != tail[i]) done = 1'b0;
    end
    check({name, "_drain_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic wait_head(input int r, input int target, input string name);
    bit done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      tick();
      done = (head[r] == target);
    end
    check({name, "_wait_timeout"}, 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int h0;
    bit stable;

    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
      for (int j = 0; j < 16; j++) begin
        src_data[i][j] = '0;
        src_last[i][j] = 1'b0;
      end
    end
    reset        = 1'b1;
    io_out_ready = 1'b1;
    io_gapCycles = 16'd0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(io_out_valid), 32'd0);
    check("rst_in_ready", 32'(io_in_ready), 32'd0);
    check("rst_busy", 32'(io_busy), 32'd0);
    tick();
    @(negedge clk);
    check("rst_grant", 32'(io_grant), 32'd0);
    tick();
    reset = 1'b0;

    // S1: requesters 1 and 2 each send a single-word frame
    push_word(1, 9'h011, 1'b1);
    push_word(2, 9'h022, 1'b1);
    expect_word(1, 9'h011);
    expect_word(2, 9'h022);
    @(negedge clk);
    check("s1_valid_not_yet", 32'(io_out_valid), 32'd0);
    @(negedge clk);
    check("s1_valid_after_1", 32'(io_out_valid), 32'd1);
    check("s1_first_grant", 32'(io_grant), 32'd1);
    wait_drain("s1");

    // S2: requester 0 three-word frame, requester 3 contends mid-frame
    push_word(0, 9'h005, 1'b0);
    push_word(0, 9'h00A, 1'b0);
    push_word(0, 9'h1FF, 1'b1);
    expect_word(0, 9'h005);
    expect_word(0, 9'h00A);
    expect_word(0, 9'h1FF);
    expect_word(3, 9'h033);
    tick();
    push_word(3, 9'h033, 1'b1);
    @(negedge clk);
    check("s2_ready_owner_only", 32'(io_in_ready), 32'b0001);
    wait_drain("s2");

    // S3: gap of 7 cycles; gap input changed mid-gap
    io_gapCycles = 16'd7;
    h0 = head[1];
    push_word(1, 9'h111, 1'b1);
    expect_word(1, 9'h111);
    wait_head(1, h0 + 1, "s3");
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!io_busy) break;
      busy_cnt++;
      if (k == 2) io_gapCycles = 16'd2;
    end
    check("s3_gap_busy_cycles", 32'(busy_cnt), 32'd7);
    io_gapCycles = 16'd0;
    wait_drain("s3");

    // S4: transmitter stalls for 20 cycles mid-frame
    h0 = head[2];
    push_word(2, 9'h0AA, 1'b0);
    push_word(2, 9'h155, 1'b1);
    expect_word(2, 9'h0AA);
    expect_word(2, 9'h155);
    wait_head(2, h0 + 1, "s4");
    io_out_ready = 1'b0;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(io_out_valid && io_out_bits == 9'h155 && io_grant == 2'd2 && io_in_ready == '0))
        stable = 1'b0;
    end
    check("s4_stall_stable", 32'(stable), 32'd1);
    check("s4_no_handshake", 32'(head[2]), 32'(h0 + 1));
    tick();
    io_out_ready = 1'b1;
    wait_drain("s4");

    // S6: reset during word 2 of requester 2's frame (sole contender, re-granted)
    h0 = head[2];
    push_word(2, 9'h0C1, 1'b0);
    push_word(2, 9'h0C2, 1'b0);
    push_word(2, 9'h0C3, 1'b1);
    expect_word(2, 9'h0C1);
    wait_head(2, h0 + 1, "s6");
    reset = 1'b1;
    @(negedge clk);
    check("s6_rst_out_valid", 32'(io_out_valid), 32'd0);
    check("s6_rst_in_ready", 32'(io_in_ready), 32'd0);
    check("s6_rst_busy", 32'(io_busy), 32'd0);
    head[2] = tail[2];
    push_word(0, 9'h0D0, 1'b1);
    push_word(3, 9'h0D3, 1'b1);
    expect_word(0, 9'h0D0);
    expect_word(3, 9'h0D3);
    tick();
    @(negedge clk);
    check("s6_rst_grant", 32'(io_grant), 32'd0);
    tick();
    reset = 1'b0;
    wait_drain("s6");

    // S5: all four requesters continuously valid, single-word frames
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < N; r++) begin
        push_word(r, W'(9'h100 + r * 16 + k), 1'b1);
        expect_word(r, W'(9'h100 + r * 16 + k));
      end
    wait_drain("s5");

    check("sb_all_consumed", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_tx_arbiter

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter W, default 9, meaning the data width, matched to the UART transmitter's io_data_bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port io_in_valid, input, N bits: per-requester word valid.
REQ-006 The block SHALL have port io_in_bits, input, N*W bits: requester i's data in bits [i*W+W-1 : i*W].
REQ-007 The block SHALL have port io_in_last, input, N bits: marks the final word of requester i's frame.
REQ-008 The block SHALL have port io_in_ready, output, N bits: per-requester ready.
REQ-009 The block SHALL have port io_out_valid, output, 1 bit: drives the transmitter's io_data_valid.
REQ-010 The block SHALL have port io_out_bits, output, W bits: drives the transmitter's io_data_bits.
REQ-011 The block SHALL have port io_out_ready, input, 1 bit: from the transmitter's io_data_ready.
REQ-012 The block SHALL have port io_gapCycles, input, 16 bits: idle cycles enforced after each frame.
REQ-013 The block SHALL have port io_grant, output, clog2(N) bits: index of the current or last owner.
REQ-014 The block SHALL have port io_busy, output, 1 bit: high in GRANT or GAP.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, GRANT, GAP.
REQ-016 In IDLE with any io_in_valid bit high, the block SHALL select the first valid requester searching round-robin from pointer+1 (mod N), register it as the owner, set pointer to it, and enter GRANT on the next edge.
REQ-017 Latency from io_in_valid rising in IDLE to io_out_valid SHALL be exactly 1 cycle.
REQ-018 In GRANT, the block SHALL drive io_out_valid = io_in_valid[g], io_out_bits = word g, io_in_ready[g] = io_out_ready, with all other io_in_ready bits 0 (combinational pass-through, no buffering).
REQ-019 Outside GRANT, io_out_valid and all io_in_ready bits SHALL be 0.
REQ-020 The grant SHALL be held across words until a handshake (valid and ready both high) occurs with io_in_last[g]=1; other requesters' valid SHALL NOT preempt it.
REQ-021 On the last handshake, if io_gapCycles = 0 the FSM SHALL go to IDLE; otherwise it SHALL load the counter with io_gapCycles (sampled that cycle) and go to GAP.
REQ-022 In GAP, the counter SHALL decrement each cycle, and the FSM SHALL enter IDLE on the edge where the counter equals 1, giving exactly io_gapCycles idle cycles.
REQ-023 Changes to io_gapCycles during GAP SHALL NOT affect the running count.
REQ-024 The owner dropping io_in_valid mid-frame SHALL NOT release the grant; the FSM SHALL wait indefinitely.
REQ-025 When requester g is the only one valid after its frame, it SHALL be re-granted (fairness applies only among contenders).
REQ-026 Pointer arithmetic SHALL wrap modulo N; for N not a power of two, indices >= N SHALL never be granted.

Reset
REQ-027 On a clock edge with reset high, the block SHALL set state IDLE, counter 0, pointer N-1 (so requester 0 has first priority), and io_grant 0.
REQ-028 Reset SHALL give io_out_valid = 0, io_in_ready = 0 and io_busy = 0 from the first reset cycle.
REQ-029 Reset asserted mid-frame or mid-gap SHALL abandon the frame with no further handshakes.

Structure
REQ-030 The FSM state encoding, N/W defaults and the gap counter width (16) SHALL live in the shared uart package.
REQ-031 The round-robin priority picker (valid vector + pointer -> one-hot/index + found flag) SHALL be a separate combinational sub-module, rr_picker.

Verification
REQ-032 Scenario 1: after reset, valid=4'b0110 with 1-word frames (last=1), out_ready=1, gap=0 -> grants 1 then 2; out_bits match each requester's word, and io_out_valid rises 1 cycle after valid.
REQ-033 Scenario 2: requester 0 sends a 3-word frame (0x05, 0x0A, last on 0x1FF) while requester 3 is valid -> three words from 0 consecutive, then grant=3; no interleaving.
REQ-034 Scenario 3: gap=7, single-word frame -> io_busy high for exactly 7 cycles after the handshake, then IDLE; io_gapCycles changed to 2 mid-gap has no effect.
REQ-035 Scenario 4: io_out_ready held 0 for 20 cycles mid-frame -> word and grant are stable, no handshake, and the frame completes once ready returns.
REQ-036 Scenario 5: all four requesters valid continuously, 1-word frames -> grant order 0,1,2,3,0 with no starvation.
REQ-037 Scenario 6: reset pulsed during word 2 of a 3-word frame -> outputs at 0 in the reset cycle; after release, requester 0 wins regardless of the prior owner.
